// File: rtl/ldpc_shift_scheduler.sv
// Walks one QC-LDPC base-matrix row through the pipelined circular shifter, skipping null entries
// and carrying column tags alongside the shifter latency. Define SCHED_PERF_EN to add the perf counters.
module ldpc_shift_scheduler #(
  parameter int unsigned MAXZ      = 81,
  parameter int unsigned SHIFT_LAT = 10,
  parameter int unsigned MAX_COLS  = 24,
  parameter int unsigned ADDR_W    = 10,
  localparam int unsigned SW       = $clog2(MAXZ),
  localparam int unsigned CW       = $clog2(MAX_COLS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] row_base,
  input  logic [CW:0]       row_len,
  input  logic [SW:0]       z_size,
  input  logic              stall,
  output logic              tbl_rd_en,
  output logic [ADDR_W-1:0] tbl_addr,
  input  logic [CW-1:0]     tbl_col,
  input  logic [SW-1:0]     tbl_shift,
  output logic              sh_issue,
  output logic [SW-1:0]     sh_shift_val,
  output logic [CW-1:0]     sh_col,
  output logic              res_valid,
  output logic [CW-1:0]     res_col,
  output logic              busy,
  output logic              done,
  output logic              err_shift
`ifdef SCHED_PERF_EN
  ,
  output logic [15:0]       perf_issue_cnt,
  output logic [15:0]       perf_stall_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0]              base_q;
  logic [CW:0]                    len_q;
  logic [CW:0]                    rd_idx;
  logic [SW:0]                    z_q;
  logic                           rd_vld;
  logic                           skid_vld;
  logic [CW-1:0]                  skid_col;
  logic [SW-1:0]                  skid_shift;
  logic [SW-1:0]                  shift_hold;
  logic [SHIFT_LAT-1:0]           tag_vld;
  logic [SHIFT_LAT-1:0][CW-1:0]   tag_col;

  logic            accept;
  logic            rd_go;
  logic            last_rd;
  logic            pres_vld;
  logic [CW-1:0]   pres_col;
  logic [SW-1:0]   pres_shift;
  logic            pres_null;
  logic            pres_err;
  logic            drain_ok;

  // Entry presented to the issue stage: the skid register has priority over fresh table data
  assign pres_vld   = skid_vld | rd_vld;
  assign pres_col   = skid_vld ? skid_col : tbl_col;
  assign pres_shift = skid_vld ? skid_shift : tbl_shift;
  assign pres_null  = &pres_shift;
  assign pres_err   = !pres_null && ({1'b0, pres_shift} >= z_q);
  assign last_rd    = (rd_idx == len_q - (CW+1)'(1));
  assign drain_ok   = !pres_vld && (tag_vld[SHIFT_LAT-2:0] == '0);

  assign sh_issue     = pres_vld && !stall && !pres_null;
  assign sh_col       = sh_issue ? pres_col : '0;
  assign sh_shift_val = sh_issue ? (pres_err ? '0 : pres_shift) : shift_hold;
  assign tbl_rd_en    = rd_go;
  assign tbl_addr     = rd_go ? base_q + ADDR_W'(rd_idx) : '0;

  assign res_valid = tag_vld[SHIFT_LAT-1];
  assign res_col   = tag_col[SHIFT_LAT-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    rd_go     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = (row_len == '0) ? DONE : FETCH;
        end
      end
      FETCH: begin
        if (!stall) begin
          rd_go = 1'b1;
          if (last_rd) state_nxt = DRAIN;
        end
      end
      DRAIN:   if (drain_ok) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q     <= '0;
      len_q      <= '0;
      rd_idx     <= '0;
      z_q        <= '0;
      rd_vld     <= 1'b0;
      skid_vld   <= 1'b0;
      skid_col   <= '0;
      skid_shift <= '0;
      shift_hold <= '0;
      err_shift  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      rd_vld <= rd_go;
      if (accept) begin
        base_q <= row_base;
        len_q  <= row_len;
        z_q    <= z_size;
        rd_idx <= '0;
      end else if (rd_go) begin
        rd_idx <= rd_idx + (CW+1)'(1);
      end
      // Returned data that cannot issue this cycle parks in the skid register
      if (rd_vld && (stall || skid_vld)) begin
        skid_vld   <= 1'b1;
        skid_col   <= tbl_col;
        skid_shift <= tbl_shift;
      end else if (!stall) begin
        skid_vld <= 1'b0;
      end
      if (sh_issue) shift_hold <= sh_shift_val;
      if (accept)                     err_shift <= 1'b0;
      else if (sh_issue && pres_err)  err_shift <= 1'b1;
      busy <= (state_nxt == FETCH) || (state_nxt == DRAIN);
      done <= (state_nxt == DONE);
    end
  end

  // Tag pipeline runs free so tags stay aligned with the shifter regardless of stall
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_vld <= '0;
      tag_col <= '0;
    end else begin
      tag_vld <= {tag_vld[SHIFT_LAT-2:0], sh_issue};
      tag_col <= {tag_col[SHIFT_LAT-2:0], sh_col};
    end
  end

`ifdef SCHED_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_issue_cnt <= '0;
      perf_stall_cnt <= '0;
    end else if (accept) begin
      perf_issue_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (sh_issue && (perf_issue_cnt != 16'hFFFF))
        perf_issue_cnt <= perf_issue_cnt + 16'd1;
      if (busy && stall && (perf_stall_cnt != 16'hFFFF))
        perf_stall_cnt <= perf_stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: doc/ldpc_shift_scheduler.md
Name: ldpc_shift_scheduler

Overview:
- Sequences one base-matrix row of a QC-LDPC layered decoder through the pipelined circular shifter.
- Fetches (column, shift) entries from the base-matrix table and skips null entries.
- Issues valid shifts to the shifter, tagging each one with its column index.
- Tracks every issue through the fixed shifter latency, so downstream logic gets a result-valid strobe and column tag aligned with the shifter output.

Parameters:
- MAXZ, 81: maximum lifting size; shift width SW = $clog2(MAXZ).
- SHIFT_LAT, 10: shifter latency in cycles, from shift_val capture to out_data valid.
- MAX_COLS, 24: maximum base-matrix columns; CW = $clog2(MAX_COLS).
- ADDR_W, 10: table address width.

Ports:
- CLK  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  one-cycle pulse; begins a row. Ignored while busy.
- row_base  in  ADDR_W  table address of the row's first entry; sampled on start.
- row_len  in  CW+1  number of entries, 0..MAX_COLS; sampled on start.
- z_size  in  SW+1  active lifting size, 1..MAXZ; sampled on start.
- stall  in  1  downstream hold; blocks new table reads.
- tbl_rd_en  out  1  table read strobe.
- tbl_addr  out  ADDR_W  table read address.
- tbl_col  in  CW  column field; valid 1 cycle after tbl_rd_en.
- tbl_shift  in  SW  shift field; valid 1 cycle after tbl_rd_en. All-ones means null entry.
- sh_issue  out  1  a new shift enters the shifter this cycle.
- sh_shift_val  out  SW  shift value driven to the shifter.
- sh_col  out  CW  column index of the current issue.
- res_valid  out  1  shifter out_data holds a valid result this cycle.
- res_col  out  CW  column tag for res_valid.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse when the row is complete.
- err_shift  out  1  sticky: a non-null shift was >= z_size. Cleared on start.

Behaviour:
- Reset state: all outputs 0, FSM in IDLE, tag pipeline cleared.
- The tag pipeline is SHIFT_LAT stages of {valid, col}. Reset inside a row discards all in-flight tags; no res_valid follows reset.
- IDLE:
  - start=1 with row_len>0 -> FETCH; latch row_base, row_len and z_size; clear err_shift; busy=1.
  - start=1 with row_len=0 -> DONE.
- FETCH:
  - Each cycle with stall=0 and reads remaining: tbl_rd_en=1, tbl_addr = row_base + read_index, read_index increments.
  - When the last read has been issued -> DRAIN.
- Return path: every read returns data exactly one cycle later, regardless of stall. The returned entry goes to a 1-entry skid register.
  - A returned entry is issued only when stall=0. If stall=1, it is held in the skid register and no further reads go out until it has been issued.
  - Issue occurs in the cycle the entry (or the skid entry) is presented with stall=0.
  - Null entry (tbl_shift all-ones): consumed with no issue and no tag.
  - Shift >= z_size (non-null): err_shift=1; issued with sh_shift_val=0.
  - Otherwise: sh_issue=1, sh_shift_val=tbl_shift, sh_col=tbl_col.
- sh_shift_val holds its last value when sh_issue=0, so the free-running shifter sees a stable input.
- Result timing: res_valid/res_col equal the tag pushed exactly SHIFT_LAT cycles earlier. stall does not freeze the tag pipeline.
- DRAIN: wait until the skid register is empty and the tag pipeline is empty, then -> DONE.
- DONE: done=1 for one cycle, busy=0, -> IDLE.
  - start may be accepted in the cycle after done.
  - start during DONE is ignored.
- Maximum throughput is one issue per cycle. Row latency with no stalls and no nulls = row_len + SHIFT_LAT + 2 cycles from start to done.

Optional Feature:
- Macro SCHED_PERF_EN.
- Defined: adds outputs perf_issue_cnt [15:0] and perf_stall_cnt [15:0].
  - perf_issue_cnt counts sh_issue cycles.
  - perf_stall_cnt counts busy cycles with stall=1.
  - Both saturate at 16'hFFFF, clear on start, and reset to 0.
- Undefined: no counters and no ports; all other behaviour is identical.

Test Plan:
- Basic row: row_len=4, shifts {3,0,80,17}, cols {0,5,9,23}, z_size=81.
  - sh_issue on 4 consecutive cycles starting 2 cycles after start.
  - res_valid exactly 10 cycles after each issue, with res_col 0,5,9,23.
  - done at cycle 16.
- Null skip: row_len=3, middle shift = 7'h7F.
  - Exactly 2 issues and 2 res_valid; done follows the last res_valid.
- Stall/skid: row_len=6, stall high for cycles 3-6 after start.
  - No tbl_rd_en during the stall; no entry lost or duplicated.
  - 6 issues in order; sh_shift_val stable while stalled.
- Range error: z_size=27, shift=30.
  - err_shift=1, issued with shift 0.
  - Next start clears err_shift.
- Reset mid-row: assert rst 5 cycles after start of a row_len=8 row.
  - All outputs 0 immediately; no res_valid in the following 12 cycles.
  - A new start after reset completes normally.
- Edge cases:
  - row_len=0: done pulse 1 cycle after start, with no tbl_rd_en.
  - start while busy: ignored, and the active row completes unchanged.
